// File: rtl/mux_rr_if.sv
// Handshake bundle between two requesters, the round-robin arbiter and one consumer.
// master = requester/consumer side, slave = arbiter side.
interface mux_rr_if #(
  parameter int N = 3
);
  logic         a_valid;
  logic [N-1:0] a_data;
  logic         a_ready;
  logic         b_valid;
  logic [N-1:0] b_data;
  logic         b_ready;
  logic         sel;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic         out_ready;

  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, sel, out_valid, out_data
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, sel, out_valid, out_data
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Two-way round-robin arbiter with bounded bursts in front of a registered 2:1 mux.
// One output register stage; readies are combinational from grant state and output space.
module mux_rr_arbiter #(
  parameter int N         = 3,
  parameter int MAX_BURST = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  mux_rr_if.slave bus
);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           last_q, last_d;   // 1 = B was served last
  logic           sel_q, sel_d;
  logic           out_valid_q, out_valid_d;
  logic [N-1:0]   out_data_q, out_data_d;

  logic space, a_fire, b_fire;
  logic x_fire, x_valid, y_valid, burst_done;

  assign space       = !out_valid_q | bus.out_ready;
  assign bus.a_ready = (state_q == GRANT_A) & space;
  assign bus.b_ready = (state_q == GRANT_B) & space;
  assign a_fire      = bus.a_valid & bus.a_ready;
  assign b_fire      = bus.b_valid & bus.b_ready;

  assign bus.sel       = sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    sel_d      = sel_q;
    x_fire     = (state_q == GRANT_A) ? a_fire      : b_fire;
    x_valid    = (state_q == GRANT_A) ? bus.a_valid : bus.b_valid;
    y_valid    = (state_q == GRANT_A) ? bus.b_valid : bus.a_valid;
    burst_done = x_fire & (cnt_q == CW'(MAX_BURST - 1));
    case (state_q)
      IDLE: begin
        if (bus.a_valid && (!bus.b_valid || last_q)) begin
          state_d = GRANT_A;
          sel_d   = 1'b0;
          cnt_d   = '0;
        end else if (bus.b_valid) begin
          state_d = GRANT_B;
          sel_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT_A, GRANT_B: begin
        if (x_fire) cnt_d = cnt_q + 1'b1;
        // Burst expiry with no rival restarts the count in place, no bubble.
        if (burst_done || !x_valid) begin
          cnt_d = '0;
          if (y_valid) begin
            state_d = (state_q == GRANT_A) ? GRANT_B : GRANT_A;
            sel_d   = (state_q == GRANT_A);
            last_d  = (state_q == GRANT_B);
          end else if (!x_valid) begin
            state_d = IDLE;
            last_d  = (state_q == GRANT_B);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (a_fire) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.a_data;
    end else if (b_fire) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.b_data;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      sel_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: per-cycle vector table plus hand sequences
// for asynchronous reset and an exhaustive single-word sweep.
module tb_mux_rr_arbiter;
  logic clk;
  logic rst_n;
  mux_rr_if #(.N(3)) bus ();

  mux_rr_arbiter #(.N(3), .MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       av;
    logic [2:0] ad;
    logic       bv;
    logic [2:0] bd;
    logic       ordy;
    logic       ar;
    logic       br;
    logic       sel;
    logic       ov;
    logic [2:0] od;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(input int r, av, ad, bv, bd, o, ar, br, s, ov, od);
    vec_t v;
    v.rst = r[0];  v.av = av[0]; v.ad = 3'(ad); v.bv = bv[0]; v.bd = 3'(bd);
    v.ordy = o[0]; v.ar = ar[0]; v.br = br[0]; v.sel = s[0]; v.ov = ov[0];
    v.od = 3'(od);
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [2:0] ad, input logic bv,
                       input logic [2:0] bd, input logic o);
    bus.a_valid = av; bus.a_data = ad; bus.b_valid = bv; bus.b_data = bd; bus.out_ready = o;
  endtask

  // One single-word request from src (0=A, 1=B); checks the word lands on the output.
  task automatic send(input logic src, input logic [2:0] d, input int tag);
    bit got = 0;
    @(posedge clk); #1;
    if (src) drive(1'b0, 3'd0, 1'b1, d, 1'b1);
    else     drive(1'b1, d, 1'b0, 3'd0, 1'b1);
    for (int k = 0; k < 8 && !got; k++) begin
      #3;
      if (src ? bus.b_ready : bus.a_ready) got = 1;
      @(posedge clk); #1;
    end
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
    #3;
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL sweep_timeout[%0d]: no ready within 8 cycles", tag);
    end else begin
      chk("sweep_ov",   tag, {7'd0, bus.out_valid}, 8'd1);
      chk("sweep_data", tag, {5'd0, bus.out_data},  {5'd0, d});
      chk("sweep_sel",  tag, {7'd0, bus.sel},       {7'd0, src});
    end
  endtask

  initial begin
    // Only A, data 0..7 back to back, no bubble at the burst wrap.
    vecs.push_back(mk(1,1,0,0,0,1, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,1, 1,0,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,1, 1,0,0,1,0));
    vecs.push_back(mk(0,1,2,0,0,1, 1,0,0,1,1));
    vecs.push_back(mk(0,1,3,0,0,1, 1,0,0,1,2));
    vecs.push_back(mk(0,1,4,0,0,1, 1,0,0,1,3));
    vecs.push_back(mk(0,1,5,0,0,1, 1,0,0,1,4));
    vecs.push_back(mk(0,1,6,0,0,1, 1,0,0,1,5));
    vecs.push_back(mk(0,1,7,0,0,1, 1,0,0,1,6));
    vecs.push_back(mk(0,0,0,0,0,1, 1,0,0,1,7));
    vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,7));
    // Both valid: A first, 4+4 alternation, sel toggles.
    vecs.push_back(mk(1,1,5,1,2,1, 0,0,0,0,0));
    vecs.push_back(mk(0,1,5,1,2,1, 1,0,0,0,0));
    vecs.push_back(mk(0,1,5,1,2,1, 1,0,0,1,5));
    vecs.push_back(mk(0,1,5,1,2,1, 1,0,0,1,5));
    vecs.push_back(mk(0,1,5,1,2,1, 1,0,0,1,5));
    vecs.push_back(mk(0,1,5,1,2,1, 0,1,1,1,5));
    vecs.push_back(mk(0,1,5,1,2,1, 0,1,1,1,2));
    vecs.push_back(mk(0,1,5,1,2,1, 0,1,1,1,2));
    vecs.push_back(mk(0,1,5,1,2,1, 0,1,1,1,2));
    vecs.push_back(mk(0,1,5,1,2,1, 1,0,0,1,2));
    vecs.push_back(mk(0,1,5,1,2,1, 1,0,0,1,5));
    // Backpressure mid-burst: count frozen, A still gets 4 before B.
    vecs.push_back(mk(1,1,1,1,6,1, 0,0,0,0,0));
    vecs.push_back(mk(0,1,1,1,6,1, 1,0,0,0,0));
    vecs.push_back(mk(0,1,2,1,6,1, 1,0,0,1,1));
    vecs.push_back(mk(0,1,3,1,6,0, 0,0,0,1,2));
    vecs.push_back(mk(0,1,3,1,6,0, 0,0,0,1,2));
    vecs.push_back(mk(0,1,3,1,6,0, 0,0,0,1,2));
    vecs.push_back(mk(0,1,3,1,6,1, 1,0,0,1,2));
    vecs.push_back(mk(0,1,4,1,6,1, 1,0,0,1,3));
    vecs.push_back(mk(0,1,5,1,6,1, 0,1,1,1,4));
    vecs.push_back(mk(0,1,5,1,6,1, 0,1,1,1,6));
    // Early release by A after 2 words; A returns after B's full burst.
    vecs.push_back(mk(1,1,1,1,7,1, 0,0,0,0,0));
    vecs.push_back(mk(0,1,1,1,7,1, 1,0,0,0,0));
    vecs.push_back(mk(0,1,2,1,7,1, 1,0,0,1,1));
    vecs.push_back(mk(0,0,0,1,7,1, 1,0,0,1,2));
    vecs.push_back(mk(0,0,0,1,7,1, 0,1,1,0,2));
    vecs.push_back(mk(0,1,3,1,7,1, 0,1,1,1,7));
    vecs.push_back(mk(0,1,3,1,7,1, 0,1,1,1,7));
    vecs.push_back(mk(0,1,3,1,7,1, 0,1,1,1,7));
    vecs.push_back(mk(0,1,3,1,7,1, 1,0,0,1,7));
    vecs.push_back(mk(0,0,0,0,0,1, 1,0,0,1,3));
    vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,3));

    rst_n = 1'b0;
    drive(1'b1, 3'd4, 1'b1, 3'd2, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ar",  0, {7'd0, bus.a_ready},   8'd0);
    chk("rst_br",  0, {7'd0, bus.b_ready},   8'd0);
    chk("rst_ov",  0, {7'd0, bus.out_valid}, 8'd0);
    chk("rst_od",  0, {5'd0, bus.out_data},  8'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      if (vecs[i].rst) begin
        rst_n = 1'b0; #1; rst_n = 1'b1;
      end else #1;
      drive(vecs[i].av, vecs[i].ad, vecs[i].bv, vecs[i].bd, vecs[i].ordy);
      #2;
      chk("a_ready",   i, {7'd0, bus.a_ready},   {7'd0, vecs[i].ar});
      chk("b_ready",   i, {7'd0, bus.b_ready},   {7'd0, vecs[i].br});
      chk("sel",       i, {7'd0, bus.sel},       {7'd0, vecs[i].sel});
      chk("out_valid", i, {7'd0, bus.out_valid}, {7'd0, vecs[i].ov});
      chk("out_data",  i, {5'd0, bus.out_data},  {5'd0, vecs[i].od});
    end

    // Asynchronous reset with a word in flight and sel=1.
    @(posedge clk); #1;
    rst_n = 1'b0; #1; rst_n = 1'b1;
    drive(1'b0, 3'd0, 1'b1, 3'd3, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    chk("pre_rst_ov",  0, {7'd0, bus.out_valid}, 8'd1);
    chk("pre_rst_sel", 0, {7'd0, bus.sel},       8'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_ov",  0, {7'd0, bus.out_valid}, 8'd0);
    chk("arst_sel", 0, {7'd0, bus.sel},       8'd0);
    chk("arst_ar",  0, {7'd0, bus.a_ready},   8'd0);
    chk("arst_br",  0, {7'd0, bus.b_ready},   8'd0);
    chk("arst_od",  0, {5'd0, bus.out_data},  8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b1);

    // Exhaustive sweep: alternate A and B single words over every data pair.
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++) begin
        send(1'b0, 3'(a), a * 8 + b);
        send(1'b1, 3'(b), a * 8 + b);
      end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
